// File: rtl/rca_seq_arbiter.sv
// Round-robin arbiter that feeds two requesters into one 8-bit ripple-carry slice, one byte per cycle.
// Accept to res_valid is NBYTES+1 edges; results hold in DONE until res_ready, and no request is taken outside IDLE.

// One-bit full adder cell; purely combinational, no handshake.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// Eight full adders with the carry rippled LSB to MSB; combinational, no handshake.
module rca8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  logic [8:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    fa u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (c[i]),
      .s_o (sum_o[i]),
      .c_o (c[i+1])
    );
  end

  assign cout_o = c[8];
endmodule

// Owns the single rca8 slice; the byte index walks LSB first and carry_q chains between bytes.
module rca_seq_arbiter #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [8*NBYTES-1:0]   req0_a,
  input  logic [8*NBYTES-1:0]   req0_b,
  input  logic                  req0_cin,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [8*NBYTES-1:0]   req1_a,
  input  logic [8*NBYTES-1:0]   req1_b,
  input  logic                  req1_cin,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   res_sum,
  output logic                  res_cout,
  output logic                  res_id,
  output logic                  busy
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            last_grant_q, last_grant_d;
  logic            id_q, id_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;

  logic            gnt0, gnt1;
  logic [7:0]      add_a, add_b, add_sum;
  logic            add_cout;

  // Ties go to whichever requester did not win last; a lone requester always wins.
  assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready = rst_n & (state_q == S_IDLE) & gnt0;
  assign req1_ready = rst_n & (state_q == S_IDLE) & gnt1;

  assign add_a = a_q[8*idx_q +: 8];
  assign add_b = b_q[8*idx_q +: 8];

  rca8 u_rca (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;

    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d      = S_ADD;
          id_d         = req1_ready;
          last_grant_d = req1_ready;
          idx_d        = '0;
          a_d          = req1_ready ? req1_a   : req0_a;
          b_d          = req1_ready ? req1_b   : req0_b;
          carry_d      = req1_ready ? req1_cin : req0_cin;
        end
      end
      S_ADD: begin
        sum_d[8*idx_q +: 8] = add_sum;
        carry_d             = add_cout;
        idx_d               = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          idx_d   = '0;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
    end
  end

  // After the last byte carry_q holds the carry out of the top byte.
  assign res_valid = (state_q == S_DONE);
  assign res_sum   = sum_q;
  assign res_cout  = carry_q;
  assign res_id    = id_q;
  assign busy      = (state_q != S_IDLE);

endmodule
